fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the fetch stage: owns the PC and issues word fetches to a variable-latency instruction memory over a req/ack handshake.
- Drives the IF/ID instruction slot and absorbs decode stalls with a 1-entry hold buffer.
- Applies branch/jump redirects with flush, and discards in-flight fetches that a redirect has made stale.
- Sits between the decode stage (PCSrc, TargetAddress, stallDetector) and instruction memory.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
MAX_WAIT, 15, request cycles without ack before FetchTimeout is set (range 1..255)

Ports:
Clk  in  1  clock, all state updates on posedge
Rst_n  in  1  asynchronous active-low reset
PCSrc  in  1  redirect request from decode; wins over everything
TargetAddress  in  32  redirect PC; bits [1:0] are forced to 00
stallDetector  in  1  0 = decode stalled (slot not consumed), 1 = decode consumes slot at this edge
MemReq  out  1  fetch request to instruction memory
MemAddr  out  32  fetch word address; stable while MemReq=1 until ack
MemAck  in  1  memory returns MemData this cycle; only meaningful when MemReq=1
MemData  in  32  instruction word
InstOut  out  32  IF/ID instruction
PCOut  out  32  address of InstOut
InstValid  out  1  InstOut holds a valid instruction
FetchTimeout  out  1  sticky: a request waited MAX_WAIT cycles

Behaviour:
- Reset (async, Rst_n=0): state=BOOT, PC=RESET_PC, MemReq=0, MemAddr=RESET_PC, InstOut=0, PCOut=0, InstValid=0, FetchTimeout=0, hold buffer empty, wait counter=0. Reset mid-fetch abandons the request; memory must tolerate MemReq dropping.
- All outputs are registered. MemAddr always equals PC, except in DISCARD, where it keeps the stale address.
- BOOT: MemReq=0. Next edge goes to FETCH. The first MemReq is high 1 cycle after reset release.
- FETCH: MemReq=1. Edge priority:
  1. PCSrc=1: PC<=Target, InstValid<=0, hold cleared. With MemAck, stay in FETCH (data dropped); without it, go to DISCARD.
  2. MemAck and (stallDetector=1 or InstValid=0): InstOut<=MemData, PCOut<=PC, InstValid<=1, PC<=PC+4, stay in FETCH. Back-to-back acks give 1 instruction per cycle.
  3. MemAck, stallDetector=0, InstValid=1: HoldReg<=MemData, HoldPC<=PC, PC<=PC+4, go to HOLD.
  4. No ack, stallDetector=1: InstValid<=0 (bubble).
  5. No ack, stallDetector=0: outputs hold.
- HOLD: MemReq=0.
  - PCSrc=1: PC<=Target, InstValid<=0, hold dropped, go to FETCH.
  - stallDetector=1: InstOut<=HoldReg, PCOut<=HoldPC, InstValid<=1, go to FETCH.
  - Otherwise stay.
- DISCARD: MemReq=1 and MemAddr stays at the stale address (a request is never withdrawn without ack). InstValid stays 0.
  - MemAck: data dropped, go to FETCH at the current PC.
  - PCSrc=1 again: PC<=new Target, stay in DISCARD. If MemAck coincides, go to FETCH at the new Target.
- Wait counter: increments each cycle MemReq=1 and MemAck=0, saturates; clears on ack, BOOT or HOLD. At count==MAX_WAIT, FetchTimeout<=1 until reset. The request continues.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Latency: with zero-wait memory (ack in the first request cycle), InstValid rises 2 edges after reset release.
- Redirect penalty: with zero-wait memory, InstValid is 0 for 1 cycle. An in-flight stale fetch adds the remaining memory latency.
- MemAck while MemReq=0 is ignored.

Test Plan:
- Reset release, RESET_PC=0, MemAck tied 1 -> MemAddr 0,4,8,... on consecutive cycles; PCOut 0,4,8 with InstValid=1 from the 2nd edge; InstOut equals MemData per address.
- Ack every 3rd request cycle, stallDetector=1 -> MemAddr held stable 3 cycles each; InstValid pulses 1 cycle per instruction; FetchTimeout stays 0.
- Slot full, stallDetector=0 for 4 cycles, MemAck=1 at address 8 -> word@8 goes to hold and MemReq drops. On release: InstOut=word@8, PCOut=8, MemAddr=12 next.
- Request to 0x10 outstanding, PCSrc=1 with TargetAddress=0x43 -> InstValid=0 and PC=0x40; MemAddr stays 0x10 until ack, that data is never presented, then MemAddr=0x40.
- PCSrc=1 in the same cycle as MemAck, stallDetector=0 -> data dropped, no HOLD entry, next MemAddr=Target; PCSrc also overrides HOLD.
- MemAck held 0 with MAX_WAIT=15 -> FetchTimeout=1 after 15 request cycles and stays 1 after a later ack. PC at 32'hFFFFFFFC with ack -> next MemAddr=0. Rst_n pulsed low mid-DISCARD -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches words over req/ack,
// fills the IF/ID slot with a 1-entry hold buffer and redirect flush.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PCSrc,
  input  logic [31:0] TargetAddress,
  input  logic        stallDetector,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic [31:0] InstOut,
  output logic [31:0] PCOut,
  output logic        InstValid,
  output logic        FetchTimeout
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } state_t;

  localparam logic [7:0] LP_MAX = MAX_WAIT[7:0];

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic [31:0] r_hold_pc;
  logic [7:0]  r_wait;
  logic        r_memreq;
  logic [31:0] r_memaddr;
  logic [31:0] r_inst;
  logic [31:0] r_pcout;
  logic        r_valid;
  logic        r_timeout;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic [7:0]  w_wait_inc;
  logic        w_ack;

  assign w_tgt      = {TargetAddress[31:2], 2'b00};
  assign w_pc_inc   = r_pc + 32'd4;
  assign w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
  assign w_ack      = r_memreq & MemAck;

  assign MemReq       = r_memreq;
  assign MemAddr      = r_memaddr;
  assign InstOut      = r_inst;
  assign PCOut        = r_pcout;
  assign InstValid    = r_valid;
  assign FetchTimeout = r_timeout;

  // Fetch FSM with registered outputs and request wait counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_hold    <= '0;
      r_hold_pc <= '0;
      r_wait    <= '0;
      r_memreq  <= 1'b0;
      r_memaddr <= RESET_PC;
      r_inst    <= '0;
      r_pcout   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_state   <= S_FETCH;
          r_memreq  <= 1'b1;
          r_memaddr <= r_pc;
        end
        S_FETCH: begin
          if (PCSrc) begin
            r_pc    <= w_tgt;
            r_valid <= 1'b0;
            if (MemAck) begin
              r_memaddr <= w_tgt;
            end else begin
              r_state <= S_DISCARD;
            end
          end else if (MemAck && (stallDetector || !r_valid)) begin
            r_inst    <= MemData;
            r_pcout   <= r_pc;
            r_valid   <= 1'b1;
            r_pc      <= w_pc_inc;
            r_memaddr <= w_pc_inc;
          end else if (MemAck) begin
            r_hold    <= MemData;
            r_hold_pc <= r_pc;
            r_pc      <= w_pc_inc;
            r_memaddr <= w_pc_inc;
            r_memreq  <= 1'b0;
            r_state   <= S_HOLD;
          end else if (stallDetector) begin
            r_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (PCSrc) begin
            r_pc      <= w_tgt;
            r_memaddr <= w_tgt;
            r_valid   <= 1'b0;
            r_memreq  <= 1'b1;
            r_state   <= S_FETCH;
          end else if (stallDetector) begin
            r_inst   <= r_hold;
            r_pcout  <= r_hold_pc;
            r_valid  <= 1'b1;
            r_memreq <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (PCSrc) begin
            r_pc <= w_tgt;
          end
          if (MemAck) begin
            r_memaddr <= PCSrc ? w_tgt : r_pc;
            r_state   <= S_FETCH;
          end
        end
        default: begin
          r_state  <= S_BOOT;
          r_memreq <= 1'b0;
        end
      endcase

      if (r_memreq && !w_ack) begin
        r_wait <= w_wait_inc;
        if (w_wait_inc == LP_MAX) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_wait <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a random
// run checked against a program-order fetch model.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] TargetAddress = '0;
  logic        stallDetector = 1'b0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemData;
  logic [31:0] InstOut;
  logic [31:0] PCOut;
  logic        InstValid;
  logic        FetchTimeout;

  int nchk = 0;
  int nerr = 0;

  fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(15)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .PCSrc(PCSrc),
    .TargetAddress(TargetAddress),
    .stallDetector(stallDetector),
    .MemReq(MemReq),
    .MemAddr(MemAddr),
    .MemAck(MemAck),
    .MemData(MemData),
    .InstOut(InstOut),
    .PCOut(PCOut),
    .InstValid(InstValid),
    .FetchTimeout(FetchTimeout)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign MemData = memf(MemAddr);

  // Holds reset for two edges, releases at a negedge (BOOT cycle).
  task automatic do_rst;
    Rst_n = 1'b0;
    PCSrc = 1'b0;
    TargetAddress = '0;
    stallDetector = 1'b0;
    MemAck = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_rst();
    nchk++;
    if ({MemReq, InstValid, FetchTimeout} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 000",
               {MemReq, InstValid, FetchTimeout});
    end
    nchk++;
    if ({MemAddr, InstOut, PCOut} !== 96'h0) begin
      nerr++;
      $display("FAIL reset_words: got %h %h %h want 0",
               MemAddr, InstOut, PCOut);
    end
  endtask

  task automatic test_stream;
    do_rst();
    stallDetector = 1'b1;
    @(negedge Clk);
    nchk++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0 || InstValid !== 1'b0) begin
      nerr++;
      $display("FAIL stream_first: got req=%b addr=%h v=%b want 1 0 0",
               MemReq, MemAddr, InstValid);
    end
    MemAck = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      nchk++;
      if (MemAddr !== 32'(4 * k) || PCOut !== 32'(4 * (k - 1)) ||
          InstValid !== 1'b1 || InstOut !== memf(32'(4 * (k - 1)))) begin
        nerr++;
        $display("FAIL stream_%0d: got addr=%h pc=%h v=%b inst=%h", k,
                 MemAddr, PCOut, InstValid, InstOut);
      end
    end
  endtask

  task automatic test_slow;
    do_rst();
    stallDetector = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      nchk++;
      if (MemAddr !== 32'(4 * (c / 3)) ||
          InstValid !== (c >= 3 && c % 3 == 0) ||
          FetchTimeout !== 1'b0) begin
        nerr++;
        $display("FAIL slow_%0d: got addr=%h v=%b to=%b want addr=%h",
                 c, MemAddr, InstValid, FetchTimeout, 32'(4 * (c / 3)));
      end
      MemAck = (c % 3 == 2);
    end
  endtask

  task automatic test_hold;
    do_rst();
    stallDetector = 1'b1;
    MemAck = 1'b1;
    repeat (3) @(negedge Clk);
    nchk++;
    if (PCOut !== 32'h4 || InstValid !== 1'b1 || MemAddr !== 32'h8) begin
      nerr++;
      $display("FAIL hold_pre: got pc=%h v=%b addr=%h want 4 1 8",
               PCOut, InstValid, MemAddr);
    end
    stallDetector = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      nchk++;
      if (MemReq !== 1'b0 || MemAddr !== 32'hC || PCOut !== 32'h4 ||
          InstValid !== 1'b1) begin
        nerr++;
        $display("FAIL hold_wait_%0d: got req=%b addr=%h pc=%h v=%b",
                 i, MemReq, MemAddr, PCOut, InstValid);
      end
    end
    stallDetector = 1'b1;
    MemAck = 1'b0;
    @(negedge Clk);
    nchk++;
    if (InstOut !== memf(32'h8) || PCOut !== 32'h8 || InstValid !== 1'b1 ||
        MemReq !== 1'b1 || MemAddr !== 32'hC) begin
      nerr++;
      $display("FAIL hold_release: got inst=%h pc=%h v=%b req=%b addr=%h",
               InstOut, PCOut, InstValid, MemReq, MemAddr);
    end
  endtask

  task automatic test_stale;
    do_rst();
    stallDetector = 1'b1;
    MemAck = 1'b1;
    repeat (5) @(negedge Clk);
    nchk++;
    if (MemAddr !== 32'h10) begin
      nerr++;
      $display("FAIL stale_pre: got %h want 10", MemAddr);
    end
    MemAck = 1'b0;
    PCSrc = 1'b1;
    TargetAddress = 32'h43;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      PCSrc = 1'b0;
      nchk++;
      if (MemAddr !== 32'h10 || MemReq !== 1'b1 || InstValid !== 1'b0) begin
        nerr++;
        $display("FAIL stale_wait_%0d: got addr=%h req=%b v=%b", i,
                 MemAddr, MemReq, InstValid);
      end
    end
    MemAck = 1'b1;
    @(negedge Clk);
    nchk++;
    if (MemAddr !== 32'h40 || InstValid !== 1'b0) begin
      nerr++;
      $display("FAIL stale_refetch: got addr=%h v=%b want 40 0",
               MemAddr, InstValid);
    end
    @(negedge Clk);
    nchk++;
    if (InstValid !== 1'b1 || PCOut !== 32'h40 ||
        InstOut !== memf(32'h40)) begin
      nerr++;
      $display("FAIL stale_target: got v=%b pc=%h inst=%h want pc 40",
               InstValid, PCOut, InstOut);
    end
  endtask

  task automatic test_redirect_ack;
    do_rst();
    stallDetector = 1'b1;
    MemAck = 1'b1;
    repeat (2) @(negedge Clk);
    stallDetector = 1'b0;
    PCSrc = 1'b1;
    TargetAddress = 32'h80;
    @(negedge Clk);
    PCSrc = 1'b0;
    nchk++;
    if (MemAddr !== 32'h80 || InstValid !== 1'b0 || MemReq !== 1'b1) begin
      nerr++;
      $display("FAIL redir_ack: got addr=%h v=%b req=%b want 80 0 1",
               MemAddr, InstValid, MemReq);
    end
    stallDetector = 1'b1;
    @(negedge Clk);
    stallDetector = 1'b0;
    @(negedge Clk);
    nchk++;
    if (MemReq !== 1'b0 || PCOut !== 32'h80) begin
      nerr++;
      $display("FAIL redir_hold: got req=%b pc=%h want 0 80",
               MemReq, PCOut);
    end
    PCSrc = 1'b1;
    TargetAddress = 32'h200;
    @(negedge Clk);
    PCSrc = 1'b0;
    nchk++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h200 || InstValid !== 1'b0) begin
      nerr++;
      $display("FAIL redir_over_hold: got req=%b addr=%h v=%b",
               MemReq, MemAddr, InstValid);
    end
    stallDetector = 1'b1;
    @(negedge Clk);
    nchk++;
    if (InstValid !== 1'b1 || PCOut !== 32'h200) begin
      nerr++;
      $display("FAIL redir_after_hold: got v=%b pc=%h want 1 200",
               InstValid, PCOut);
    end
  endtask

  task automatic test_timeout;
    do_rst();
    stallDetector = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge Clk);
      nchk++;
      if (FetchTimeout !== (c >= 15)) begin
        nerr++;
        $display("FAIL timeout_%0d: got %b want %b", c, FetchTimeout,
                 (c >= 15));
      end
    end
    MemAck = 1'b1;
    repeat (3) @(negedge Clk);
    nchk++;
    if (FetchTimeout !== 1'b1 || InstValid !== 1'b1) begin
      nerr++;
      $display("FAIL timeout_sticky: got to=%b v=%b want 1 1",
               FetchTimeout, InstValid);
    end
  endtask

  task automatic test_wrap;
    do_rst();
    stallDetector = 1'b1;
    @(negedge Clk);
    MemAck = 1'b1;
    PCSrc = 1'b1;
    TargetAddress = 32'hFFFF_FFFF;
    @(negedge Clk);
    PCSrc = 1'b0;
    nchk++;
    if (MemAddr !== 32'hFFFF_FFFC || InstValid !== 1'b0) begin
      nerr++;
      $display("FAIL wrap_pre: got addr=%h v=%b want fffffffc 0",
               MemAddr, InstValid);
    end
    @(negedge Clk);
    nchk++;
    if (MemAddr !== 32'h0 || PCOut !== 32'hFFFF_FFFC ||
        InstOut !== memf(32'hFFFF_FFFC)) begin
      nerr++;
      $display("FAIL wrap: got addr=%h pc=%h inst=%h want 0 fffffffc",
               MemAddr, PCOut, InstOut);
    end
  endtask

  task automatic test_reset_discard;
    do_rst();
    stallDetector = 1'b1;
    MemAck = 1'b1;
    repeat (4) @(negedge Clk);
    MemAck = 1'b0;
    PCSrc = 1'b1;
    TargetAddress = 32'h100;
    @(negedge Clk);
    PCSrc = 1'b0;
    nchk++;
    if (MemReq !== 1'b1 || MemAddr !== 32'hC || PCOut !== 32'h8 ||
        InstValid !== 1'b0) begin
      nerr++;
      $display("FAIL rstd_pre: got req=%b addr=%h pc=%h v=%b",
               MemReq, MemAddr, PCOut, InstValid);
    end
    #2 Rst_n = 1'b0;
    #1;
    nchk++;
    if ({MemReq, InstValid, FetchTimeout} !== 3'b000 ||
        {MemAddr, InstOut, PCOut} !== 96'h0) begin
      nerr++;
      $display("FAIL rstd_async: got req=%b v=%b addr=%h inst=%h pc=%h",
               MemReq, InstValid, MemAddr, InstOut, PCOut);
    end
  endtask

  // Program-order model: each slot decode takes must be the next
  // sequential PC, or the last redirect target, with the matching word.
  task automatic test_random;
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] tgt;
    int          consumed;
    do_rst();
    exp_pc = 32'h0;
    pend = 1'b0;
    pend_addr = '0;
    consumed = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge Clk);
      if (pend) begin
        nchk++;
        if (MemReq !== 1'b1 || MemAddr !== pend_addr) begin
          nerr++;
          $display("FAIL rand_req_stable@%0d: got req=%b addr=%h want %h",
                   cyc, MemReq, MemAddr, pend_addr);
        end
      end
      stallDetector = ($urandom_range(3) != 0);
      MemAck = ($urandom_range(2) == 0);
      PCSrc = (cyc > 2) && ($urandom_range(11) == 0);
      tgt = $urandom;
      TargetAddress = tgt;
      if (InstValid && stallDetector) begin
        consumed++;
        nchk++;
        if (PCOut !== exp_pc || InstOut !== memf(exp_pc)) begin
          nerr++;
          $display("FAIL rand_order@%0d: got pc=%h inst=%h want pc=%h",
                   cyc, PCOut, InstOut, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (PCSrc) exp_pc = {tgt[31:2], 2'b00};
      pend = MemReq && !MemAck;
      pend_addr = MemAddr;
    end
    nchk++;
    if (consumed < 30) begin
      nerr++;
      $display("FAIL rand_progress: got %0d instructions want >= 30",
               consumed);
    end
    PCSrc = 1'b0;
    MemAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_slow();
    test_hold();
    test_stale();
    test_redirect_ack();
    test_timeout();
    test_wrap();
    test_reset_discard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
